// File: rtl/song_sram_loader_pkg.sv
// Shared definitions for the song-program SRAM: opcode nibbles, program base
// address and the loader state encoding. The player imports the opcodes too.
package song_sram_loader_pkg;

    localparam logic [3:0]  OP_END   = 4'h0;
    localparam logic [3:0]  OP_BPM   = 4'h1;
    localparam logic [3:0]  OP_REP1  = 4'h2;
    localparam logic [3:0]  OP_REP2  = 4'h3;
    localparam int          NOTE_BIT = 15;

    localparam logic [17:0] PROG_BASE_ADDR = 18'h0FF00;

    typedef enum logic [3:0] {
        IDLE,
        RECV_HI,
        RECV_LO,
        CHECK,
        SETUP,
        WRITE,
        HOLD,
        FIN,
        ERR
    } loaderState_e;

    function automatic logic opcodeValid(input logic [15:0] word);
        return word[NOTE_BIT] ||
               (word[15:12] inside {OP_END, OP_BPM, OP_REP1, OP_REP2});
    endfunction

    function automatic logic isEndWord(input logic [15:0] word);
        return word[15:12] == OP_END;
    endfunction

endpackage

// File: rtl/sram_write_strobe.sv
// Generic SRAM write-enable strober: GO held for one setup cycle launches a
// WE_CYCLES-long active-low pulse; DONE marks the last low cycle.
module sram_write_strobe #(
    parameter int WE_CYCLES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic GO,
    output logic SRAM_WE,
    output logic DONE
);

    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    logic [CW-1:0] remain;

    // WE is a flop so it comes straight out of async reset high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SRAM_WE <= 1'b1;
            remain  <= '0;
        end else if (SRAM_WE) begin
            if (GO) begin
                SRAM_WE <= 1'b0;
                remain  <= CW'(WE_CYCLES - 1);
            end
        end else if (remain == '0) begin
            SRAM_WE <= 1'b1;
        end else begin
            remain <= remain - CW'(1);
        end
    end

    assign DONE = !SRAM_WE && (remain == '0);

endmodule

// File: rtl/song_sram_loader.sv
// Host byte stream to SRAM program loader: packs big-endian byte pairs into
// instruction words, validates opcodes and writes them from BASE_ADDR up.
module song_sram_loader
    import song_sram_loader_pkg::*;
#(
    parameter logic [17:0] BASE_ADDR = PROG_BASE_ADDR,
    parameter int          WE_CYCLES = 2,
    parameter int          MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    output logic        SRAM_WE,
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [15:0] WORD_COUNT
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    loaderState_e state, nextState;
    logic         startLoad;
    logic         strobeGo;
    logic         strobeDone;

    sram_write_strobe #(
        .WE_CYCLES(WE_CYCLES)
    ) u_strobe (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .GO     (strobeGo),
        .SRAM_WE(SRAM_WE),
        .DONE   (strobeDone)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState  = state;
        IN_READY   = 1'b0;
        BUSY       = 1'b0;
        SRAM_DQ_OE = 1'b0;
        strobeGo   = 1'b0;
        startLoad  = 1'b0;
        unique case (state)
            IDLE, FIN, ERR: begin
                startLoad = START;
                if (START) nextState = RECV_HI;
            end
            RECV_HI: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (IN_VALID) nextState = RECV_LO;
            end
            RECV_LO: begin
                IN_READY = 1'b1;
                BUSY     = 1'b1;
                if (IN_VALID) nextState = CHECK;
            end
            CHECK: begin
                BUSY = 1'b1;
                if (!opcodeValid(SRAM_DQ_OUT) || WORD_COUNT == MAX_COUNT)
                    nextState = ERR;
                else
                    nextState = SETUP;
            end
            SETUP: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                strobeGo   = 1'b1;
                nextState  = WRITE;
            end
            WRITE: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                if (strobeDone) nextState = HOLD;
            end
            HOLD: begin
                BUSY       = 1'b1;
                SRAM_DQ_OE = 1'b1;
                nextState  = isEndWord(SRAM_DQ_OUT) ? FIN : RECV_HI;
            end
            default: nextState = IDLE;
        endcase
    end

    assign SRAM_CE = !BUSY;
    assign SRAM_OE = 1'b1;
    assign SRAM_LB = 1'b0;
    assign SRAM_UB = 1'b0;

    // The word register doubles as the DQ driver; it is only overwritten
    // while receiving, when the bus is not driven.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SRAM_A      <= BASE_ADDR;
            SRAM_DQ_OUT <= '0;
            WORD_COUNT  <= '0;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            if (startLoad) begin
                SRAM_A     <= BASE_ADDR;
                WORD_COUNT <= '0;
                DONE       <= 1'b0;
                ERROR      <= 1'b0;
            end
            if (state == RECV_HI && IN_VALID) SRAM_DQ_OUT[15:8] <= IN_DATA;
            if (state == RECV_LO && IN_VALID) SRAM_DQ_OUT[7:0]  <= IN_DATA;
            if (state == CHECK && nextState == ERR) ERROR <= 1'b1;
            if (state == HOLD) begin
                WORD_COUNT <= WORD_COUNT + 16'd1;
                SRAM_A     <= SRAM_A + 18'd1;
                if (nextState == FIN) DONE <= 1'b1;
            end
        end
    end

endmodule

// File: doc/song_sram_loader.md
Name: song_sram_loader

Overview:
- Writer side of the song-program SRAM interface: takes a byte stream from a host link, packs bytes into 16-bit instruction words, and writes them to external SRAM starting at the program base address the player fetches from.
- Sits between the host byte receiver and the SRAM pins. It owns the bus while BUSY; the top level gives the bus back to the player once BUSY falls.
- Checks opcodes as it writes and stops after the END instruction is written.

Parameters:
BASE_ADDR, 18'h0FF00, SRAM word address of the first instruction; the player's reset PC.
WE_CYCLES, 2, number of clock cycles SRAM_WE is held low per write (must be ≥1).
MAX_WORDS, 256, maximum words accepted per load, including END.

Ports:
CLK  in  1  system clock, 50 MHz.
RST_N  in  1  asynchronous active-low reset.
START  in  1  one-cycle pulse that begins a new load.
IN_VALID  in  1  a byte is available on IN_DATA.
IN_DATA  in  8  stream byte, high byte of each word first.
IN_READY  out  1  loader accepts a byte this cycle.
SRAM_WE  out  1  write enable, active low.
SRAM_CE  out  1  chip enable, active low.
SRAM_OE  out  1  output enable, active low; held 1 by this block.
SRAM_LB  out  1  lower byte enable, active low; constant 0.
SRAM_UB  out  1  upper byte enable, active low; constant 0.
SRAM_A  out  18  word address.
SRAM_DQ_OUT  out  16  write data.
SRAM_DQ_OE  out  1  top-level tristate enable for SRAM_DQ_OUT.
BUSY  out  1  load in progress; the player must be held paused.
DONE  out  1  sticky: last load ended cleanly on END.
ERROR  out  1  sticky: last load aborted.
WORD_COUNT  out  16  words written in the current or last load.

Behaviour:
- Reset values: SRAM_WE=1, SRAM_CE=1, SRAM_OE=1, SRAM_LB=0, SRAM_UB=0, SRAM_A=BASE_ADDR, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, IN_READY=0, BUSY=0, DONE=0, ERROR=0, WORD_COUNT=0. The state machine resets to IDLE.
- States: IDLE, RECV_HI, RECV_LO, CHECK, SETUP, WRITE, HOLD, FIN, ERR.
- IDLE, FIN, ERR:
  - On START: A=BASE_ADDR, WORD_COUNT=0, DONE=0, ERROR=0, go to RECV_HI.
  - START in any other state is ignored.
- RECV_HI, RECV_LO:
  - IN_READY=1 combinationally from state only.
  - A byte is taken when IN_VALID && IN_READY; with no valid byte, the state is held indefinitely.
  - RECV_HI latches word[15:8]; RECV_LO latches word[7:0], then goes to CHECK.
- CHECK (1 cycle), opcode decode:
  - Valid opcodes: word[15]=1 (note), or word[15:12] in {0000 END, 0001 BPM, 0010 REP1, 0011 REP2}.
  - word[15:12] in 0100..0111 → ERR, word not written.
  - WORD_COUNT==MAX_WORDS → ERR, word not written.
  - Otherwise go to SETUP.
- SETUP (1 cycle): SRAM_A and SRAM_DQ_OUT stable, SRAM_DQ_OE=1, SRAM_WE=1.
- WRITE: SRAM_WE=0 for exactly WE_CYCLES cycles; address and data unchanged.
- HOLD (1 cycle): SRAM_WE=1 with data still driven.
  - On exit: WORD_COUNT+1; A+1, wrapping 18'h3FFFF→0.
  - If the written word was END → FIN, else → RECV_HI.
- Per-word write latency from the low byte being accepted: 1+1+WE_CYCLES+1 cycles, 5 at default.
- While BUSY (RECV_HI through HOLD): SRAM_CE=0 and BUSY=1. In IDLE/FIN/ERR: SRAM_CE=1, SRAM_DQ_OE=0, BUSY=0.
- FIN sets DONE=1. ERR sets ERROR=1. Both are sticky until the next START or reset.
- Reset asserted mid-write forces SRAM_WE=1 and SRAM_DQ_OE=0 immediately (asynchronous).
- IN_DATA is ignored whenever IN_READY=0.

Decomposition:
- Shared package holds:
  - opcode nibble constants (END, BPM, REP1, REP2), note flag bit 15, opcode-valid function;
  - default program base 18'h0FF00;
  - state enum.
- The player uses the same opcode constants from this package.
- One natural sub-module: sram_write_strobe, with inputs go and WE_CYCLES, outputs SRAM_WE and a done pulse. It covers SETUP/WRITE/HOLD timing and is reusable by any future SRAM writer.

Test Plan:
- START, bytes 10 60 | 81 23 | 00 00 → writes 0x1060@0FF00, 0x8123@0FF01, 0x0000@0FF02; DONE=1, WORD_COUNT=3, BUSY falls after HOLD of the third word.
- Per write, check timing: SRAM_WE low for exactly 2 cycles; A and DQ stable from SETUP through HOLD; OE=1 throughout.
- Bytes 45 00 → ERROR=1, no WE pulse, WORD_COUNT=0; a later START then 00 00 → DONE=1, ERROR=0.
- MAX_WORDS=2 with 80 00 | 80 01 | 80 02 → two writes, then ERROR=1, WORD_COUNT=2.
- IN_VALID gaps of 0–7 random cycles, plus START pulsed mid-load → data and addresses identical to the gap-free run; START has no effect.
- RST_N low during the WRITE state → SRAM_WE=1, SRAM_DQ_OE=0, SRAM_CE=1 in the same cycle; all outputs at reset values.
